// File: rtl/kernel_stream_pkg.sv
// Shared types and constants for the kernel stream sink: FSM state encoding,
// flopoco exception codes and the default stream word width.
package kernel_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] EXC_ZERO   = 2'b00;
    localparam logic [1:0] EXC_NORMAL = 2'b01;
    localparam logic [1:0] EXC_INF    = 2'b10;
    localparam logic [1:0] EXC_NAN    = 2'b11;

    localparam int STREAMW_DEFAULT = 34;

endpackage

// File: rtl/kernel_stream_sink_fifo.sv
// stream_sync_fifo: circular word buffer with AW+1-bit pointers and a
// registered read port (rd_data/rd_valid appear one cycle after a pop).
module stream_sync_fifo #(
    parameter int STREAMW = 34,
    parameter int AW      = 4,
    parameter int DEPTH   = 1 << AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [STREAMW-1:0] wr_data,
    input  logic               pop,
    output logic [STREAMW-1:0] rd_data,
    output logic               rd_valid,
    output logic               full,
    output logic               empty
);

    logic [STREAMW-1:0] mem [DEPTH];
    logic [AW:0]        wptr;
    logic [AW:0]        rptr;

    // The extra pointer bit separates a full buffer from an empty one.
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr     <= '0;
            rptr     <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= pop;
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rd_data <= mem[rptr[AW-1:0]];
                rptr    <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/kernel_stream_sink.sv
// Terminal sink for a kernel output stream: buffers words, counts a frame, flags done.
// Optional KERNEL_STREAM_SINK_FPSTRIP_EN strips and checks the flopoco exception bits.
module kernel_stream_sink
    import kernel_stream_pkg::*;
#(
    parameter int STREAMW = STREAMW_DEFAULT,
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int NWORDS  = 1024,
    parameter int CNTW    = 11,
`ifdef KERNEL_STREAM_SINK_FPSTRIP_EN
    localparam int RDW    = STREAMW - 2
`else
    localparam int RDW    = STREAMW
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ivalid,
    input  logic [STREAMW-1:0] in1,
    output logic               iready,
    input  logic               start,
    input  logic               rd_en,
    output logic [RDW-1:0]     rd_data,
    output logic               rd_valid,
    output logic [CNTW-1:0]    count,
    output logic               fifo_empty,
    output logic               done,
    output logic               proto_err
);

    state_t state;
    logic   full;
    logic   empty;
    logic   push;
    logic   pop;
    logic   exc_bad;

    // Ready comes only from registered state, never from ivalid.
    assign iready     = (state == RUN) && !full;
    assign push       = ivalid && iready;
    assign pop        = rd_en && !empty;
    assign fifo_empty = empty;

`ifdef KERNEL_STREAM_SINK_FPSTRIP_EN
    assign exc_bad = push && (in1[STREAMW-1:STREAMW-2] != EXC_NORMAL);
`else
    assign exc_bad = 1'b0;
`endif

    stream_sync_fifo #(
        .STREAMW (RDW),
        .AW      (AW),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .wr_data  (in1[RDW-1:0]),
        .pop      (pop),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .full     (full),
        .empty    (empty)
    );

    // Error setting is placed after the state case so it wins over a start clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            count     <= '0;
            done      <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (push) begin
                count <= count + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        count     <= '0;
                        done      <= 1'b0;
                        proto_err <= 1'b0;
                    end
                end
                RUN: begin
                    if (push && (count == CNTW'(NWORDS - 1))) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (empty) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    if (start) begin
                        state <= RUN;
                        count <= '0;
                        done  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            if ((ivalid && (state != RUN)) || exc_bad) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule
